tick_slot_scheduler: RTL and testbench

Round-robin scheduler that shares one programmable modulo-N tick counter among NREQ requesters. A granted requester gets exclusive use of the counter for a timed slot of `limit` cycles. It is told when the slot completes, or the slot is cut short if it withdraws. The block sits between multiple timing clients and a single counter datapath, serialising their timed intervals.

---
 rtl/tick_slot_pkg.sv | 50 +++++
 rtl/tick_slot_scheduler_counter.sv | 37 +++
 rtl/tick_slot_scheduler.sv | 129 ++++++++++++
 tb/tb_tick_slot_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/tick_slot_pkg.sv
// Shared types and helpers for the tick slot scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: state enum, index width sized for the largest supported NREQ,
// and the circular round-robin search helpers used during arbitration.
package tick_slot_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Requester indices are carried at the width of the largest supported
  // configuration (8), so the helpers work for any NREQ in 2..8.
  localparam int NREQ_MAX = 8;
  localparam int IDXW     = $clog2(NREQ_MAX);

  // Index following i, wrapping at nreq.
  function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] i,
                                              input int nreq);
    if (int'(i) >= nreq - 1) return '0;
    return i + IDXW'(1);
  endfunction

  // First set bit of req, searching circularly upward from ptr.
  // Returns ptr when nothing is set; callers gate on req != 0.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                              input logic [IDXW-1:0] ptr,
                                              input int nreq);
    logic [IDXW-1:0] sel;
    logic [IDXW-1:0] jj;
    logic            found;
    int              j;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        jj = j[IDXW-1:0];
        if (!found && req[jj]) begin
          sel   = jj;
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/tick_slot_scheduler_counter.sv
// Modulo-lim tick counter owned by whichever requester holds the slot.
// Latency: count updates one cycle after en/clr; last is combinational from count and lim.
// Backpressure: none; clr has priority over en.
// Ports: clk, rst (async, active-high), clr, en, lim[W] in; count[W], last out.
module mod_n_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign last  = (count_q == lim - W'(1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/tick_slot_scheduler.sv
// Round-robin scheduler that hands one modulo-N tick counter to NREQ requesters for timed slots.
// Latency: grant appears one cycle after the arbitration edge; done/err are one-cycle registered pulses.
// Backpressure: requests wait while a slot runs; a dropped req aborts the running slot at the next edge.
// Ports: clk, rst (async, active-high), req[NREQ], limit_flat[NREQ*W] in;
//        gnt[NREQ] (one-hot), busy, count[W], done[NREQ], err out.
module tick_slot_scheduler
  import tick_slot_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] limit_flat,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [W-1:0]    count,
  output logic [NREQ-1:0] done,
  output logic            err
);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [W-1:0]      lim_q, lim_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;

  logic [NREQ_MAX-1:0] req_ext;
  logic [W-1:0]        lims [NREQ_MAX];
  logic [IDXW-1:0]     sel;
  logic [NREQ_MAX-1:0] idx_onehot;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_last;

  // Unused requester slots read as zero-length and never requesting.
  assign req_ext = NREQ_MAX'(req);
  for (genvar g = 0; g < NREQ_MAX; g++) begin : g_lims
    if (g < NREQ) begin : g_used
      assign lims[g] = limit_flat[g*W +: W];
    end else begin : g_unused
      assign lims[g] = '0;
    end
  end

  assign sel        = rr_pick(req_ext, rr_q, NREQ);
  assign idx_onehot = NREQ_MAX'(1) << idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    lim_d   = lim_q;
    done_d  = '0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ext != '0) begin
          if (lims[sel] != '0) begin
            state_d = RUN;
            idx_d   = sel;
            lim_d   = lims[sel];
            cnt_clr = 1'b1;
          end else begin
            // Zero-length slot: reject and move the pointer past it so
            // it cannot starve the others.
            err_d = 1'b1;
            rr_d  = rr_next(sel, NREQ);
          end
        end
      end
      RUN: begin
        if (!req_ext[idx_q]) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          rr_d    = rr_next(idx_q, NREQ);
        end else begin
          // The counter wraps itself to 0 on the last tick.
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d = IDLE;
            done_d  = NREQ'(idx_onehot);
            rr_d    = rr_next(idx_q, NREQ);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      lim_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      lim_q   <= lim_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  mod_n_counter #(.W(W)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .lim   (lim_q),
    .count (count),
    .last  (cnt_last)
  );

  // Decoded purely from registers, so no input-to-output combinational path.
  assign busy = (state_q == RUN);
  assign gnt  = busy ? NREQ'(idx_onehot) : '0;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_tick_slot_scheduler.sv
module tb_tick_slot_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] limit_flat;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [W-1:0]    count;
  logic [NREQ-1:0] done;
  logic            err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_slot_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .limit_flat (limit_flat),
    .gnt        (gnt),
    .busy       (busy),
    .count      (count),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic b,
                         input logic [3:0] c, input logic [3:0] d, input logic e);
    chk({tag, ".gnt"},   32'(gnt),   32'(g));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".err"},   32'(err),   32'(e));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lim(input int i, input logic [3:0] v);
    limit_flat[i*W +: W] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] g_exp;
    rst        = 1'b1;
    req        = '0;
    limit_flat = '0;
    #12;
    chk_out("reset", 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single request, limit 3
    set_lim(0, 4'd3);
    req = 4'b0001;
    step(); chk_out("t1.c0", 4'b0001, 1'b1, 4'd0, 4'b0000, 1'b0);
    step(); chk_out("t1.c1", 4'b0001, 1'b1, 4'd1, 4'b0000, 1'b0);
    step(); chk_out("t1.c2", 4'b0001, 1'b1, 4'd2, 4'b0000, 1'b0);
    step(); chk_out("t1.done", 4'b0000, 1'b0, 4'd0, 4'b0001, 1'b0);
    req = 4'b0000;
    step(); chk_out("t1.idle", 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0);

    // 2: round robin between 0 and 1, limits 2 and 2, starting from rr=0
    do_reset();
    set_lim(0, 4'd2);
    set_lim(1, 4'd2);
    req = 4'b0011;
    for (int s = 0; s < 4; s++) begin
      g_exp = (s % 2 == 1) ? 4'b0010 : 4'b0001;
      step(); chk_out($sformatf("t2.s%0d.c0", s), g_exp, 1'b1, 4'd0, 4'b0000, 1'b0);
      step(); chk_out($sformatf("t2.s%0d.c1", s), g_exp, 1'b1, 4'd1, 4'b0000, 1'b0);
      step(); chk_out($sformatf("t2.s%0d.done", s), 4'b0000, 1'b0, 4'd0, g_exp, 1'b0);
      if (s == 3) req = 4'b0000;
    end

    // 3: zero limit on requester 2 (rr=2 now)
    set_lim(2, 4'd0);
    req = 4'b0100;
    step(); chk_out("t3.err", 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b1);
    set_lim(3, 4'd2);
    req = 4'b1100;
    step(); chk_out("t3.g3", 4'b1000, 1'b1, 4'd0, 4'b0000, 1'b0);
    step(); chk_out("t3.c1", 4'b1000, 1'b1, 4'd1, 4'b0000, 1'b0);
    step(); chk_out("t3.done", 4'b0000, 1'b0, 4'd0, 4'b1000, 1'b0);
    req = 4'b0000;

    // 4: withdrawal of requester 1 at count 4, requester 2 pending (rr=0)
    set_lim(1, 4'd10);
    set_lim(2, 4'd1);
    req = 4'b0110;
    step(); chk_out("t4.g1", 4'b0010, 1'b1, 4'd0, 4'b0000, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step(); chk_out($sformatf("t4.c%0d", c), 4'b0010, 1'b1, 4'(c), 4'b0000, 1'b0);
    end
    req = 4'b0100;
    step(); chk_out("t4.wd", 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0);
    step(); chk_out("t4.g2", 4'b0100, 1'b1, 4'd0, 4'b0000, 1'b0);
    step(); chk_out("t4.done2", 4'b0000, 1'b0, 4'd0, 4'b0100, 1'b0);
    req = 4'b0000;

    // 5: async reset at count 5 of requester 3's slot (rr=3)
    set_lim(3, 4'd9);
    req = 4'b1000;
    step(); chk_out("t5.g3", 4'b1000, 1'b1, 4'd0, 4'b0000, 1'b0);
    for (int c = 1; c <= 5; c++) step();
    chk("t5.c5", 32'(count), 32'd5);
    #3;
    rst = 1'b1;
    #1;
    chk_out("t5.rst", 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0);
    #2;
    rst = 1'b0;
    set_lim(0, 4'd1);
    req = 4'b1001;
    step(); chk_out("t5.g0", 4'b0001, 1'b1, 4'd0, 4'b0000, 1'b0);
    step(); chk_out("t5.done0", 4'b0000, 1'b0, 4'd0, 4'b0001, 1'b0);
    req = 4'b0000;

    // 6: max limit 15 on requester 1 (rr=1), limit changed mid-slot
    set_lim(1, 4'd15);
    req = 4'b0010;
    step(); chk_out("t6.c0", 4'b0010, 1'b1, 4'd0, 4'b0000, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) set_lim(1, 4'd5);
      step(); chk_out($sformatf("t6.c%0d", c), 4'b0010, 1'b1, 4'(c), 4'b0000, 1'b0);
    end
    step(); chk_out("t6.done", 4'b0000, 1'b0, 4'd0, 4'b0010, 1'b0);
    req = 4'b0000;
    step(); chk_out("t6.idle", 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
